// File: rtl/fetch_instr_queue.sv
// Decoupling queue between the fetch unit and the back end.
// Buffers fetched instruction packets in a circular buffer and hands them to
// the back end in order over a valid/ready handshake. A flush or resolved
// misprediction drops every buffered packet. After an excepting packet is
// accepted the queue stops accepting packets until the next flush, while the
// excepting packet itself still drains to the back end.
module fetch_instr_queue #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned XLEN       = 64,
    parameter int unsigned ILEN       = 32,
    parameter int unsigned EXCEPT_LEN = 5
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        flush_i,
    input  logic                        mispredict_i,

    input  logic                        fetch_valid_i,
    output logic                        fetch_ready_o,
    input  logic [XLEN-1:0]             fetch_pc_i,
    input  logic [ILEN-1:0]             fetch_instr_i,
    input  logic [XLEN-1:0]             fetch_pred_target_i,
    input  logic                        fetch_pred_taken_i,
    input  logic                        fetch_except_raised_i,
    input  logic [EXCEPT_LEN-1:0]       fetch_except_code_i,

    output logic                        be_valid_o,
    input  logic                        be_ready_i,
    output logic [XLEN-1:0]             curr_pc_o,
    output logic [ILEN-1:0]             instruction_o,
    output logic [XLEN-1:0]             pred_target_o,
    output logic                        pred_taken_o,
    output logic                        except_raised_o,
    output logic [EXCEPT_LEN-1:0]       except_code_o,
    output logic [$clog2(DEPTH):0]      count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t             state;
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [CNT_W-1:0]   count;

    logic [XLEN-1:0]        pc_mem     [DEPTH];
    logic [ILEN-1:0]        instr_mem  [DEPTH];
    logic [XLEN-1:0]        target_mem [DEPTH];
    logic                   taken_mem  [DEPTH];
    logic                   exc_mem    [DEPTH];
    logic [EXCEPT_LEN-1:0]  code_mem   [DEPTH];

    logic flush_any;
    logic push;
    logic pop;

    // Handshake qualifiers; reset forces both sides of the queue idle.
    always_comb begin
        flush_any     = flush_i || mispredict_i;
        fetch_ready_o = !rst_i && (state == RUN) && (count < FULL_CNT);
        be_valid_o    = !rst_i && (count != '0);
        push          = fetch_valid_i && fetch_ready_o;
        pop           = be_valid_o && be_ready_i;
        count_o       = rst_i ? '0 : count;
    end

    // Head entry is presented combinationally to the back end.
    always_comb begin
        curr_pc_o       = pc_mem[head];
        instruction_o   = instr_mem[head];
        pred_target_o   = target_mem[head];
        pred_taken_o    = taken_mem[head];
        except_raised_o = exc_mem[head];
        except_code_o   = code_mem[head];
    end

    // Control state: pointers, occupancy and the exception hold FSM.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= RUN;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush_any) begin
            state <= RUN;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
                if (fetch_except_raised_i) begin
                    state <= HOLD;
                end
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Packet storage; entries are not reset, only written on an accepted push.
    always_ff @(posedge clk_i) begin
        if (push && !flush_any) begin
            pc_mem[tail]     <= fetch_pc_i;
            instr_mem[tail]  <= fetch_instr_i;
            target_mem[tail] <= fetch_pred_target_i;
            taken_mem[tail]  <= fetch_pred_taken_i;
            exc_mem[tail]    <= fetch_except_raised_i;
            code_mem[tail]   <= fetch_except_code_i;
        end
    end

endmodule
